// File: rtl/operand_reader_pkg.sv
// operand_reader_pkg: shared state encoding and defaults for the operand byte reader
package operand_reader_pkg;
  typedef enum logic [1:0] {ORD_IDLE, ORD_FETCH, ORD_DONE} ord_state_t;
  localparam int ORD_MAX_BYTES_DEFAULT = 4;
endpackage

// File: rtl/operand_extend.sv
// operand_extend: places n little-endian bytes into an OUT_W word, sign- or zero-filling above them
module operand_extend #(
  parameter int MAX_BYTES = 4,
  parameter int OUT_W = 8 * MAX_BYTES,
  parameter int CNT_W = $clog2(MAX_BYTES + 1)
) (
  input  logic [8*MAX_BYTES-1:0] data,
  input  logic [CNT_W-1:0]       n,
  input  logic                   sign_extend,
  output logic [OUT_W-1:0]       result
);
  logic [OUT_W-1:0] wide;
  logic             fill;
  always_comb begin
    wide = OUT_W'(data);
    fill = 1'b0;
    for (int i = 0; i < MAX_BYTES; i++) fill = int'(n) == i + 1 ? sign_extend && data[8*i+7] : fill;
    for (int i = 0; i < OUT_W; i++) result[i] = i / 8 < int'(n) ? wide[i] : fill;
  end
endmodule

// File: rtl/operand_byte_reader.sv
// operand_byte_reader: pops 0..MAX_BYTES bytes from the prefetch FIFO into one extended operand.
// OPERAND_READER_BYPASS_EN selects same-cycle completion; otherwise completion is registered via DONE.
module operand_byte_reader
  import operand_reader_pkg::*;
#(
  parameter int MAX_BYTES = ORD_MAX_BYTES_DEFAULT,
  parameter int OUT_W = 8 * MAX_BYTES,
  parameter int CNT_W = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [CNT_W-1:0] num_bytes,
  input  logic             sign_extend,
  output logic             busy,
  output logic             complete,
  output logic [OUT_W-1:0] result,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
  input  logic             fifo_empty
);
  localparam int BW = 8 * MAX_BYTES;
`ifdef OPERAND_READER_BYPASS_EN
  localparam ord_state_t FIN = ORD_IDLE;
`else
  localparam ord_state_t FIN = ORD_DONE;
`endif
  ord_state_t state, state_n;
  logic [CNT_W-1:0] idx, cnt, n_clamp, cur_idx, cur_cnt, ext_n;
  logic sx, start_ok, zero_done, fetching, pop, last, ext_sx, done, drop;
  logic [BW-1:0] acc, base, acc_n, ext_data;
  logic [OUT_W-1:0] ext;
  always_comb begin
    n_clamp = num_bytes > CNT_W'(MAX_BYTES) ? CNT_W'(MAX_BYTES) : num_bytes;
    start_ok = state == ORD_IDLE && start && n_clamp != '0 && !flush && !reset;
    zero_done = state == ORD_IDLE && start && num_bytes == '0 && !flush && !reset;
    fetching = start_ok || (state == ORD_FETCH && !flush && !reset);
    cur_idx = state == ORD_FETCH ? idx : '0;
    cur_cnt = state == ORD_FETCH ? cnt : n_clamp;
    pop = fetching && !fifo_empty;
    last = pop && cur_idx == cur_cnt - 1'b1;
    // IDLE never carries bytes forward, so a new read cannot see stale lanes
    base = state == ORD_IDLE ? '0 : acc;
    acc_n = pop ? base | (BW'(fifo_rd_data) << {cur_idx, 3'b000}) : base;
    state_n = state == ORD_DONE ? ORD_IDLE : last ? FIN : fetching ? ORD_FETCH : ORD_IDLE;
`ifdef OPERAND_READER_BYPASS_EN
    ext_data = acc_n;
    ext_n = cur_cnt;
    ext_sx = state == ORD_FETCH ? sx : sign_extend;
    done = last;
    drop = last;
`else
    ext_data = acc;
    ext_n = cnt;
    ext_sx = sx;
    done = state == ORD_DONE && !flush && !reset;
    drop = 1'b0;
`endif
  end
  always_ff @(posedge clk)
    if (reset || flush) begin
      state <= ORD_IDLE;
      idx <= '0;
      acc <= '0;
      cnt <= '0;
      sx <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      idx <= pop ? (last ? '0 : cur_idx + 1'b1) : idx;
      cnt <= start_ok ? n_clamp : cnt;
      sx <= start_ok ? sign_extend : sx;
    end
  operand_extend #(.MAX_BYTES(MAX_BYTES), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_ext (
    .data(ext_data),
    .n(ext_n),
    .sign_extend(ext_sx),
    .result(ext)
  );
  assign fifo_rd_en = pop;
  assign complete = done || zero_done;
  assign busy = (state != ORD_IDLE || start_ok) && !flush && !reset && !drop;
  assign result = reset || zero_done ? '0 : done ? ext : OUT_W'(acc);
endmodule

// File: tb/tb_operand_byte_reader.sv
// tb_operand_byte_reader: scenario tasks plus randomized reads checked against an arithmetic reference
module tb_operand_byte_reader;
  localparam int MB = 4;
  localparam int OW = 32;
  localparam int CW = 3;
`ifdef OPERAND_READER_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic reset, start, flush, sign_extend, busy, complete, fifo_rd_en, fifo_empty;
  logic [CW-1:0] num_bytes;
  logic [OW-1:0] result;
  logic [7:0] fifo_rd_data;
  always #5 clk = ~clk;
  operand_byte_reader dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .num_bytes(num_bytes),
    .sign_extend(sign_extend), .busy(busy), .complete(complete), .result(result),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty)
  );
  int checks = 0, fails = 0;
  byte unsigned fifo_q[$], loaded[$];
  bit stall_pat[$];
  bit stall;
  int pops, done_cyc, rd_bad;
  logic obs_busy[64], obs_cmp[64], obs_rd[64];
  logic [OW-1:0] obs_res[64];
  logic [OW-1:0] got;
  task automatic upd();
    fifo_empty = stall || fifo_q.size() == 0;
    fifo_rd_data = fifo_q.size() != 0 ? fifo_q[0] : 8'h00;
  endtask
  function automatic logic [OW-1:0] ref_res(input int n, input bit sx);
    longint unsigned v = 0;
    int m = n > MB ? MB : n;
    byte unsigned top;
    for (int k = 0; k < m; k++) v |= longint'(loaded[k]) << (8 * k);
    if (m > 0) begin
      top = loaded[m-1];
      if (sx && top[7]) v |= ~64'h0 << (8 * m);
    end
    return v[OW-1:0];
  endfunction
  function automatic int ref_done(input int n);
    int m = n > MB ? MB : n;
    int c = 0, p = 0;
    if (m == 0) return 0;
    while (p < m) begin
      if (!(c < stall_pat.size() && stall_pat[c])) p++;
      c++;
    end
    return c - 1 + LAT;
  endfunction
  task automatic run(input int n, input bit sx, input int flush_cyc, input int reset_cyc,
                     input int restart_cyc, input int restart_n, input int stop_cyc);
    loaded = fifo_q;
    pops = 0;
    done_cyc = -1;
    rd_bad = 0;
    for (int c = 0; c < 64; c++) begin
      start = c == 0 || c == restart_cyc;
      num_bytes = c == 0 ? CW'(n) : CW'(restart_n);
      sign_extend = c == 0 ? sx : ~sx;
      flush = c == flush_cyc;
      reset = c == reset_cyc;
      stall = c < stall_pat.size() ? stall_pat[c] : 1'b0;
      upd();
      @(negedge clk);
      obs_busy[c] = busy;
      obs_cmp[c] = complete;
      obs_rd[c] = fifo_rd_en;
      obs_res[c] = result;
      if (fifo_rd_en && fifo_empty) rd_bad++;
      if (complete && done_cyc < 0) done_cyc = c;
      @(posedge clk);
      #1;
      if (obs_rd[c]) begin
        void'(fifo_q.pop_front());
        pops++;
      end
      if (done_cyc >= 0 || c == stop_cyc) break;
    end
    start = 0;
    flush = 0;
    reset = 0;
    stall = 0;
    fifo_q.delete();
    stall_pat.delete();
    upd();
    got = done_cyc >= 0 ? obs_res[done_cyc] : 'x;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (complete !== 1'b0) begin fails++; $display("FAIL reset_complete got %b exp 0", complete); end
    checks++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
    checks++; if (result !== '0) begin fails++; $display("FAIL reset_result got %h exp 0", result); end
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    checks++; if ({busy, complete, fifo_rd_en} !== 3'b000) begin fails++; $display("FAIL idle_outputs got %b exp 000", {busy, complete, fifo_rd_en}); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_sign_byte();
    fifo_q = {8'h80};
    run(1, 1, -1, -1, -1, 0, 20);
    checks++; if (got !== 32'hFFFFFF80) begin fails++; $display("FAIL sign_byte_result got %h exp ffffff80", got); end
    checks++; if (done_cyc !== LAT) begin fails++; $display("FAIL sign_byte_latency got %0d exp %0d", done_cyc, LAT); end
    checks++; if (pops !== 1) begin fails++; $display("FAIL sign_byte_pops got %0d exp 1", pops); end
  endtask
  task automatic test_four_bytes();
    int gaps = 0;
    fifo_q = {8'h34, 8'h12, 8'h00, 8'hF0};
    run(4, 0, -1, -1, -1, 0, 20);
    for (int c = 0; c < done_cyc; c++) if (obs_busy[c] !== 1'b1) gaps++;
    checks++; if (got !== 32'hF0001234) begin fails++; $display("FAIL four_result got %h exp f0001234", got); end
    checks++; if (done_cyc !== 3 + LAT) begin fails++; $display("FAIL four_latency got %0d exp %0d", done_cyc, 3 + LAT); end
    checks++; if (pops !== 4) begin fails++; $display("FAIL four_pops got %0d exp 4", pops); end
    checks++; if (gaps !== 0) begin fails++; $display("FAIL four_busy_gaps got %0d exp 0", gaps); end
  endtask
  task automatic test_stall();
    int stalled_rd;
    fifo_q = {8'hFF, 8'h7F};
    stall_pat = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    run(2, 1, -1, -1, -1, 0, 20);
    stalled_rd = int'(obs_rd[1]) + int'(obs_rd[2]) + int'(obs_rd[3]);
    checks++; if (got !== 32'h00007FFF) begin fails++; $display("FAIL stall_result got %h exp 00007fff", got); end
    checks++; if (done_cyc !== 4 + LAT) begin fails++; $display("FAIL stall_latency got %0d exp %0d", done_cyc, 4 + LAT); end
    checks++; if (stalled_rd !== 0 || rd_bad !== 0) begin fails++; $display("FAIL stall_no_pop got %0d/%0d exp 0/0", stalled_rd, rd_bad); end
    checks++; if (pops !== 2) begin fails++; $display("FAIL stall_pops got %0d exp 2", pops); end
  endtask
  task automatic test_flush();
    fifo_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run(4, 1, 2, -1, -1, 0, 5);
    checks++; if (done_cyc !== -1) begin fails++; $display("FAIL flush_no_complete got %0d exp -1", done_cyc); end
    checks++; if (pops !== 2) begin fails++; $display("FAIL flush_pops got %0d exp 2", pops); end
    checks++; if (obs_busy[3] !== 1'b0) begin fails++; $display("FAIL flush_busy_after got %b exp 0", obs_busy[3]); end
    fifo_q = {8'h05};
    run(1, 1, -1, -1, -1, 0, 20);
    checks++; if (got !== 32'h00000005) begin fails++; $display("FAIL flush_next_result got %h exp 00000005", got); end
    checks++; if (done_cyc !== LAT) begin fails++; $display("FAIL flush_next_latency got %0d exp %0d", done_cyc, LAT); end
  endtask
  task automatic test_zero_and_restart();
    fifo_q = {8'hAA};
    run(0, 1, -1, -1, -1, 0, 10);
    checks++; if (done_cyc !== 0) begin fails++; $display("FAIL zero_latency got %0d exp 0", done_cyc); end
    checks++; if (got !== '0) begin fails++; $display("FAIL zero_result got %h exp 0", got); end
    checks++; if (pops !== 0 || obs_rd[0] !== 1'b0) begin fails++; $display("FAIL zero_pops got %0d exp 0", pops); end
    fifo_q = {8'h11, 8'h22, 8'h83, 8'h44};
    run(3, 0, -1, -1, 1, 1, 20);
    checks++; if (got !== 32'h00832211) begin fails++; $display("FAIL restart_result got %h exp 00832211", got); end
    checks++; if (pops !== 3) begin fails++; $display("FAIL restart_pops got %0d exp 3", pops); end
    checks++; if (done_cyc !== 2 + LAT) begin fails++; $display("FAIL restart_latency got %0d exp %0d", done_cyc, 2 + LAT); end
  endtask
  task automatic test_reset_mid();
    fifo_q = {8'h01, 8'h02, 8'h03};
    run(3, 0, -1, 1, -1, 0, 2);
    checks++; if ({obs_busy[1], obs_cmp[1], obs_rd[1]} !== 3'b000) begin fails++; $display("FAIL midreset_ctrl got %b exp 000", {obs_busy[1], obs_cmp[1], obs_rd[1]}); end
    checks++; if (obs_res[1] !== '0) begin fails++; $display("FAIL midreset_result got %h exp 0", obs_res[1]); end
    checks++; if ({obs_busy[2], obs_cmp[2], obs_rd[2]} !== 3'b000) begin fails++; $display("FAIL postreset_ctrl got %b exp 000", {obs_busy[2], obs_cmp[2], obs_rd[2]}); end
    checks++; if (obs_res[2] !== '0) begin fails++; $display("FAIL postreset_result got %h exp 0", obs_res[2]); end
    checks++; if (pops !== 1 || done_cyc !== -1) begin fails++; $display("FAIL midreset_pops got %0d/%0d exp 1/-1", pops, done_cyc); end
    fifo_q = {8'hC3, 8'h81};
    run(2, 1, -1, -1, -1, 0, 20);
    checks++; if (got !== 32'hFFFF81C3) begin fails++; $display("FAIL midreset_next got %h exp ffff81c3", got); end
    checks++; if (done_cyc !== 1 + LAT) begin fails++; $display("FAIL midreset_next_latency got %0d exp %0d", done_cyc, 1 + LAT); end
  endtask
  task automatic test_random();
    int n, m, exp_done;
    bit sx;
    logic [OW-1:0] exp_res;
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 7);
      sx = 1'($urandom_range(0, 1));
      m = n > MB ? MB : n;
      for (int k = 0; k < 6; k++) fifo_q.push_back(8'($urandom));
      for (int k = 0; k < 12; k++) stall_pat.push_back($urandom_range(0, 9) < 3);
      loaded = fifo_q;
      exp_res = ref_res(n, sx);
      exp_done = ref_done(n);
      run(n, sx, -1, -1, -1, 0, 40);
      checks++; if (got !== exp_res) begin fails++; $display("FAIL rand%0d_result n=%0d got %h exp %h", it, n, got, exp_res); end
      checks++; if (done_cyc !== exp_done) begin fails++; $display("FAIL rand%0d_latency got %0d exp %0d", it, done_cyc, exp_done); end
      checks++; if (pops !== m) begin fails++; $display("FAIL rand%0d_pops got %0d exp %0d", it, pops, m); end
      checks++; if (rd_bad !== 0) begin fails++; $display("FAIL rand%0d_pop_empty got %0d exp 0", it, rd_bad); end
    end
  endtask
  initial begin
    reset = 1;
    start = 0;
    flush = 0;
    num_bytes = '0;
    sign_extend = 0;
    stall = 0;
    upd();
    test_reset();
    test_sign_byte();
    test_four_bytes();
    test_stall();
    test_flush();
    test_zero_and_restart();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
